// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_pkg: shared encodings for the multi-cycle RV32I control path  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_PC     = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_LUI      = 4'd4,
    S_AUIPC    = 4'd5,
    S_ALU_WB   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu_decoder.sv
// +--------------------------------------------------------------------+
// | riscv_alu_decoder: selects the ALU operation for the current state  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (state_i)
      S_EXEC_R: alu_op_o = {funct7_5_i, funct3_i};
      // IR[30] is an immediate bit for OP-IMM except on the shift-right pair
      S_EXEC_I: alu_op_o = (funct3_i == 3'b101) ? {funct7_5_i, funct3_i}
                                                 : {1'b0, funct3_i};
      S_BRANCH: alu_op_o = ALU_SUB;
      default:  alu_op_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_mc_ctrl.sv
// +--------------------------------------------------------------------+
// | riscv_mc_ctrl: multi-cycle RV32I sequencer over one shared memory   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter state_e RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] result_sel,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_e     state_q, state_d;
  logic       illegal_q;
  logic [3:0] alu_op_w;

  riscv_alu_decoder u_alu_dec (
    .state_i    (state_q),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_op_o   (alu_op_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_OP:               state_d = S_EXEC_R;
          OPC_OP_IMM:           state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
          OPC_BRANCH:           state_d = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OPC_JAL:              state_d = S_JAL;
          OPC_JALR:             state_d = S_JALR;
          OPC_LUI:              state_d = S_LUI;
          OPC_AUIPC:            state_d = S_AUIPC;
          default:              state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  // Reset overrides everything so an in-flight memory request is dropped at once
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_RS1;
    alu_src_b  = SRC_B_RS2;
    result_sel = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_EXEC_I, S_MEM_ADDR: alu_src_b = SRC_B_IMM;
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_sel = RES_MDR;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_BRANCH: begin
        pc_write = branch_taken(funct3, zero, lt, ltu);
        pc_src   = pc_write;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        reg_write  = 1'b1;
        result_sel = RES_PC;
      end
      S_JALR: begin
        alu_src_b  = SRC_B_IMM;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_sel = RES_PC;
      end
      default: ;
    endcase
    alu_op    = alu_op_w;
    illegal   = illegal_q;
    state_dbg = state_q;
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      result_sel = 2'd0;
      alu_op     = 4'd0;
      illegal    = 1'b0;
      state_dbg  = 4'd0;
    end
  end

endmodule

`default_nettype wire
